// File: rtl/sabit_nokta_pkg.sv
// Shared definitions for the 8.2 fixed-point <-> BCD conversion chain.
package sabit_nokta_pkg;

    // Encoder FSM states
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CARP1 = 4'd1,
        CARP2 = 4'd2,
        KESIR = 4'd3,
        YUV0  = 4'd4,
        YUV1  = 4'd5,
        YUV2  = 4'd6,
        YUV3  = 4'd7,
        SON   = 4'd8
    } durum_t;

    // One quarter expressed in hundredths, and the half-quarter rounding offset
    localparam logic [6:0] ONDA_BOLUM = 7'd25;
    localparam logic [6:0] YUVARLAMA  = 7'd12;

    // Largest integer part representable in the 8.2 format
    localparam logic [9:0] MAKS_TAM   = 10'd255;

    // 8.2 format widths, shared with the divider
    localparam int SN_TAM_GEN   = 8;
    localparam int SN_KESIR_GEN = 2;
    localparam int SN_TOPLAM    = SN_TAM_GEN + SN_KESIR_GEN;

    // A BCD digit is valid only in the range 0..9
    function automatic logic bcd_gecerli(input logic [3:0] hane);
        return (hane <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_carp10_topla.sv
// Combinational multiply-by-ten-and-add: cikis = giris*10 + hane (10-bit).
module bcd_carp10_topla (
    input  logic [9:0] giris,
    input  logic [3:0] hane,
    output logic [9:0] cikis
);

    // x*10 = x*8 + x*2; operands never exceed 99*10+9, so 10 bits suffice
    always_comb begin
        cikis = (giris << 3) + (giris << 1) + {6'b0, hane};
    end

endmodule

// File: rtl/bcd_sabit_nokta_kodlayici.sv
// Sequential encoder: 3.2-digit BCD (000.00..255.99) to unsigned 8.2 fixed point,
// fraction rounded to the nearest quarter with ties rounding up.
module bcd_sabit_nokta_kodlayici
    import sabit_nokta_pkg::*;
#(
    parameter int TAM_GEN   = 8,
    parameter int KESIR_GEN = 2,
    parameter int DOYMA     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         baslat,
    input  logic [3:0]                   yuzler,
    input  logic [3:0]                   onlar,
    input  logic [3:0]                   birler,
    input  logic [3:0]                   ondalik1,
    input  logic [3:0]                   ondalik2,
    output logic                         mesgul,
    output logic                         hazir,
    output logic [TAM_GEN+KESIR_GEN-1:0] sonuc,
    output logic                         hata,
    output logic                         tasma
);

    localparam int SONUC_W = TAM_GEN + KESIR_GEN;

    durum_t     durum, durum_sonraki;
    logic       yakala;

    logic [3:0] yuz_r, on_r, bir_r, d1_r, d2_r;
    logic       gecersiz_r;
    logic [9:0] acc;
    logic [6:0] h;
    logic [2:0] q;

    logic [9:0] carp_giris;
    logic [3:0] carp_hane;
    logic [9:0] carp_cikis;

    logic [2:0] q_son;
    logic       tam_tasi;
    logic [9:0] t_son;
    logic [1:0] f_son;

    // Out-of-range integer part: saturate to all-ones or force zero
    function automatic logic [SONUC_W-1:0] doyur(input logic [9:0] t, input logic [1:0] f);
        if (t > MAKS_TAM)
            return (DOYMA != 0) ? '1 : '0;
        else
            return {t[TAM_GEN-1:0], f};
    endfunction

    bcd_carp10_topla u_carp10 (
        .giris (carp_giris),
        .hane  (carp_hane),
        .cikis (carp_cikis)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            durum <= IDLE;
        else
            durum <= durum_sonraki;
    end

    // Next state; SON (the hazir cycle) accepts a new start so back-to-back runs lose no cycle
    always_comb begin
        durum_sonraki = durum;
        yakala        = 1'b0;
        case (durum)
            IDLE, SON: begin
                if (baslat) begin
                    yakala        = 1'b1;
                    durum_sonraki = CARP1;
                end else begin
                    durum_sonraki = IDLE;
                end
            end
            CARP1:   durum_sonraki = gecersiz_r ? SON : CARP2;
            CARP2:   durum_sonraki = KESIR;
            KESIR:   durum_sonraki = YUV0;
            YUV0:    durum_sonraki = YUV1;
            YUV1:    durum_sonraki = YUV2;
            YUV2:    durum_sonraki = YUV3;
            YUV3:    durum_sonraki = SON;
            default: durum_sonraki = IDLE;
        endcase
    end

    // Operand mux for the shared multiply-by-ten adder
    always_comb begin
        carp_giris = {6'b0, yuz_r};
        carp_hane  = on_r;
        case (durum)
            CARP2: begin
                carp_giris = acc;
                carp_hane  = bir_r;
            end
            KESIR: begin
                carp_giris = {6'b0, d1_r};
                carp_hane  = d2_r;
            end
            default: ;
        endcase
    end

    // Final result, folding in the last subtraction step so it can be registered leaving YUV3
    always_comb begin
        q_son    = (h >= ONDA_BOLUM) ? q + 3'd1 : q;
        tam_tasi = (q_son == 3'd4);
        t_son    = acc + {9'b0, tam_tasi};
        f_son    = tam_tasi ? 2'b00 : q_son[1:0];
    end

    // Datapath: digit capture, integer accumulation and quarter counting
    always_ff @(posedge clk) begin
        if (yakala) begin
            yuz_r      <= yuzler;
            on_r       <= onlar;
            bir_r      <= birler;
            d1_r       <= ondalik1;
            d2_r       <= ondalik2;
            gecersiz_r <= !(bcd_gecerli(yuzler) && bcd_gecerli(onlar) && bcd_gecerli(birler)
                            && bcd_gecerli(ondalik1) && bcd_gecerli(ondalik2));
        end
        case (durum)
            CARP1, CARP2: acc <= carp_cikis;
            KESIR: begin
                h <= carp_cikis[6:0] + YUVARLAMA;
                q <= 3'd0;
            end
            YUV0, YUV1, YUV2, YUV3: begin
                if (h >= ONDA_BOLUM) begin
                    h <= h - ONDA_BOLUM;
                    q <= q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Registered status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mesgul <= 1'b0;
            hazir  <= 1'b0;
            hata   <= 1'b0;
            tasma  <= 1'b0;
            sonuc  <= '0;
        end else begin
            hazir <= 1'b0;
            if (yakala)
                mesgul <= 1'b1;
            if (durum == CARP1 && gecersiz_r) begin
                mesgul <= 1'b0;
                hazir  <= 1'b1;
                hata   <= 1'b1;
                tasma  <= 1'b0;
                sonuc  <= '0;
            end else if (durum == YUV3) begin
                mesgul <= 1'b0;
                hazir  <= 1'b1;
                hata   <= 1'b0;
                tasma  <= (t_son > MAKS_TAM);
                sonuc  <= doyur(t_son, f_son);
            end
        end
    end

endmodule

// File: tb/tb_bcd_sabit_nokta_kodlayici.sv
// Self-checking bench for the BCD to 8.2 fixed-point encoder.
module tb_bcd_sabit_nokta_kodlayici;

    logic       clk;
    logic       rst_n;
    logic       baslat;
    logic [3:0] yuzler, onlar, birler, ondalik1, ondalik2;
    logic       mesgul, hazir, hata, tasma;
    logic [9:0] sonuc;

    int checks = 0;
    int errors = 0;

    bcd_sabit_nokta_kodlayici dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baslat   (baslat),
        .yuzler   (yuzler),
        .onlar    (onlar),
        .birler   (birler),
        .ondalik1 (ondalik1),
        .ondalik2 (ondalik2),
        .mesgul   (mesgul),
        .hazir    (hazir),
        .sonuc    (sonuc),
        .hata     (hata),
        .tasma    (tasma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value in hundredths, rounded to nearest quarter (ties up) by integer arithmetic
    function automatic void model(input logic [3:0] a, b, c, d, e,
                                  output logic [9:0] s, output logic ht, output logic ts);
        int x, hund, qt, t;
        if (a > 9 || b > 9 || c > 9 || d > 9 || e > 9) begin
            s = 10'd0; ht = 1'b1; ts = 1'b0;
            return;
        end
        x    = int'(a) * 100 + int'(b) * 10 + int'(c);
        hund = int'(d) * 10 + int'(e);
        qt   = (x * 400 + hund * 4 + 50) / 100;
        t    = qt / 4;
        ht   = 1'b0;
        ts   = (t > 255);
        s    = ts ? 10'h3FF : 10'(qt);
    endfunction

    task automatic scramble();
        yuzler   = 4'($urandom_range(0, 15));
        onlar    = 4'($urandom_range(0, 15));
        birler   = 4'($urandom_range(0, 15));
        ondalik1 = 4'($urandom_range(0, 15));
        ondalik2 = 4'($urandom_range(0, 15));
    endtask

    // Start one conversion and wait (bounded) for hazir; reports the edge it appeared on
    task automatic run(input logic [3:0] a, b, c, d, e, output int kenar, output int mesgul_say);
        @(negedge clk);
        yuzler = a; onlar = b; birler = c; ondalik1 = d; ondalik2 = e;
        baslat = 1'b1;
        @(posedge clk); #1;
        kenar = 1;
        mesgul_say = mesgul ? 1 : 0;
        @(negedge clk);
        baslat = 1'b0;
        scramble();
        while (kenar < 20) begin
            @(posedge clk); #1;
            kenar++;
            if (hazir) break;
            if (mesgul) mesgul_say++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; baslat = 1'b1;
        yuzler = 4'd1; onlar = 4'd2; birler = 4'd3; ondalik1 = 4'd4; ondalik2 = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mesgul, hazir, hata, tasma, sonuc} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got m=%b h=%b e=%b t=%b s=%h want all 0",
                     mesgul, hazir, hata, tasma, sonuc);
        end
        @(negedge clk);
        baslat = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0] dg [8][5];
        logic [9:0] es [8];
        logic       et [8];
        int kenar, msay;
        dg[0] = '{4'd0, 4'd0, 4'd6, 4'd2, 4'd5}; es[0] = 10'b0000011001; et[0] = 1'b0;
        dg[1] = '{4'd0, 4'd2, 4'd0, 4'd5, 4'd0}; es[1] = 10'b0001010010; et[1] = 1'b0;
        dg[2] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2}; es[2] = 10'b0000110000; et[2] = 1'b0;
        dg[3] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd3}; es[3] = 10'b0000110001; et[3] = 1'b0;
        dg[4] = '{4'd0, 4'd9, 4'd9, 4'd9, 4'd0}; es[4] = 10'b0110010000; et[4] = 1'b0;
        dg[5] = '{4'd2, 4'd5, 4'd5, 4'd8, 4'd8}; es[5] = 10'h3FF;        et[5] = 1'b1;
        dg[6] = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0}; es[6] = 10'h3FF;        et[6] = 1'b1;
        dg[7] = '{4'd2, 4'd5, 4'd5, 4'd8, 4'd7}; es[7] = 10'h3FF;        et[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run(dg[i][0], dg[i][1], dg[i][2], dg[i][3], dg[i][4], kenar, msay);
            checks++;
            if (kenar != 8) begin
                errors++;
                $display("FAIL dir%0d_latency got edge %0d want 8", i, kenar);
            end
            checks++;
            if (sonuc !== es[i] || tasma !== et[i] || hata !== 1'b0 || mesgul !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result got s=%b t=%b e=%b m=%b want s=%b t=%b e=0 m=0",
                         i, sonuc, tasma, hata, mesgul, es[i], et[i]);
            end
            if (i == 0) begin
                checks++;
                if (msay != 7) begin
                    errors++;
                    $display("FAIL mesgul_width got %0d want 7", msay);
                end
                @(posedge clk); #1;
                checks++;
                if (hazir !== 1'b0) begin
                    errors++;
                    $display("FAIL hazir_pulse got %b want 0", hazir);
                end
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (sonuc !== es[0]) begin
                    errors++;
                    $display("FAIL sonuc_hold got %b want %b", sonuc, es[0]);
                end
            end
        end
    endtask

    task automatic test_invalid();
        int kenar, msay;
        run(4'd1, 4'd2, 4'd3, 4'hA, 4'd0, kenar, msay);
        checks++;
        if (kenar != 2) begin
            errors++;
            $display("FAIL invalid_latency got edge %0d want 2", kenar);
        end
        checks++;
        if (hata !== 1'b1 || sonuc !== 10'd0 || tasma !== 1'b0) begin
            errors++;
            $display("FAIL invalid_result got e=%b s=%h t=%b want e=1 s=0 t=0", hata, sonuc, tasma);
        end
        run(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, kenar, msay);
        checks++;
        if (hata !== 1'b0 || sonuc !== 10'b0000000100 || kenar != 8) begin
            errors++;
            $display("FAIL invalid_clear got e=%b s=%b edge=%0d want e=0 s=0000000100 edge=8",
                     hata, sonuc, kenar);
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b, c, d, e;
        logic [9:0] es;
        logic       eh, et;
        int kenar, msay;
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 3));
            b = 4'($urandom_range(0, 9));
            c = 4'($urandom_range(0, 9));
            d = 4'($urandom_range(0, 9));
            e = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) b = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) e = 4'($urandom_range(10, 15));
            model(a, b, c, d, e, es, eh, et);
            run(a, b, c, d, e, kenar, msay);
            checks++;
            if (sonuc !== es || hata !== eh || tasma !== et || kenar != (eh ? 2 : 8)) begin
                errors++;
                $display("FAIL rand%0d %0d%0d%0d.%0d%0d got s=%h e=%b t=%b edge=%0d want s=%h e=%b t=%b edge=%0d",
                         i, a, b, c, d, e, sonuc, hata, tasma, kenar, es, eh, et, eh ? 2 : 8);
            end
        end
    endtask

    task automatic test_ignore();
        logic [9:0] es;
        logic       eh, et;
        int kenar;
        int fazla;
        model(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, es, eh, et);
        @(negedge clk);
        yuzler = 4'd1; onlar = 4'd2; birler = 4'd3; ondalik1 = 4'd4; ondalik2 = 4'd5;
        baslat = 1'b1;
        @(posedge clk); #1;
        kenar = 1;
        while (kenar < 20) begin
            @(negedge clk);
            baslat = (kenar == 3 || kenar == 5);
            yuzler = 4'd0; onlar = 4'd0; birler = 4'd7; ondalik1 = 4'd0; ondalik2 = 4'd0;
            @(posedge clk); #1;
            kenar++;
            if (hazir) break;
        end
        @(negedge clk);
        baslat = 1'b0;
        checks++;
        if (kenar != 8 || sonuc !== es) begin
            errors++;
            $display("FAIL ignore_result got s=%h edge=%0d want s=%h edge=8", sonuc, kenar, es);
        end
        fazla = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mesgul || hazir) fazla++;
        end
        checks++;
        if (fazla != 0) begin
            errors++;
            $display("FAIL ignore_queue got %0d busy cycles want 0", fazla);
        end
    endtask

    task automatic test_reset_mid();
        int kenar, msay, hz;
        run(4'd3, 4'd0, 4'd0, 4'd0, 4'd0, kenar, msay);
        @(negedge clk);
        yuzler = 4'd0; onlar = 4'd1; birler = 4'd0; ondalik1 = 4'd0; ondalik2 = 4'd0;
        baslat = 1'b1;
        @(posedge clk);
        @(negedge clk);
        baslat = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mesgul, hazir, hata, tasma, sonuc} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid got m=%b h=%b e=%b t=%b s=%h want all 0",
                     mesgul, hazir, hata, tasma, sonuc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hz = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (hazir || mesgul) hz++;
        end
        checks++;
        if (hz != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles want 0", hz);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] esa, esb;
        logic       eh, eta, etb;
        int kenar;
        model(4'd0, 4'd4, 4'd2, 4'd3, 4'd7, esa, eh, eta);
        model(4'd2, 4'd5, 4'd5, 4'd9, 4'd9, esb, eh, etb);
        @(negedge clk);
        yuzler = 4'd0; onlar = 4'd4; birler = 4'd2; ondalik1 = 4'd3; ondalik2 = 4'd7;
        baslat = 1'b1;
        @(posedge clk); #1;
        kenar = 1;
        @(negedge clk);
        yuzler = 4'd2; onlar = 4'd5; birler = 4'd5; ondalik1 = 4'd9; ondalik2 = 4'd9;
        while (kenar < 20) begin
            @(posedge clk); #1;
            kenar++;
            if (hazir) break;
        end
        checks++;
        if (kenar != 8 || sonuc !== esa || tasma !== eta) begin
            errors++;
            $display("FAIL b2b_first got s=%h t=%b edge=%0d want s=%h t=%b edge=8",
                     sonuc, tasma, kenar, esa, eta);
        end
        @(posedge clk); #1;
        kenar++;
        checks++;
        if (mesgul !== 1'b1 || hazir !== 1'b0) begin
            errors++;
            $display("FAIL b2b_recapture got m=%b h=%b want m=1 h=0", mesgul, hazir);
        end
        @(negedge clk);
        baslat = 1'b0;
        scramble();
        while (kenar < 30) begin
            @(posedge clk); #1;
            kenar++;
            if (hazir) break;
        end
        checks++;
        if (kenar != 16 || sonuc !== esb || tasma !== etb) begin
            errors++;
            $display("FAIL b2b_second got s=%h t=%b edge=%0d want s=%h t=%b edge=16",
                     sonuc, tasma, kenar, esb, etb);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        baslat = 1'b0;
        yuzler = '0; onlar = '0; birler = '0; ondalik1 = '0; ondalik2 = '0;
        test_reset();
        test_directed();
        test_invalid();
        test_random();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
